// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, instruction field positions, opcodes,
// decode-stage FSM encoding and the execute payload bundle.
package pipe_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 4;
  localparam int OP_W   = 4;
  localparam int NREG   = 16;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RS1_HI = 7;
  localparam int RS1_LO = 4;
  localparam int RS2_HI = 3;
  localparam int RS2_LO = 0;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_NOP  = 4'h0;
  localparam op_t OP_ADD  = 4'h1;
  localparam op_t OP_SUB  = 4'h2;
  localparam op_t OP_AND  = 4'h3;
  localparam op_t OP_OR   = 4'h4;
  localparam op_t OP_XOR  = 4'h5;
  localparam op_t OP_NOT  = 4'h6;
  localparam op_t OP_LI   = 4'h7;
  localparam op_t OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_HOLD   = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  typedef struct packed {
    op_t               op;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } ex_t;

  // Ops that produce a result and go to execute.
  function automatic logic is_alu(input op_t op);
    return (op >= OP_ADD) && (op <= OP_LI);
  endfunction

  function automatic logic uses_rs1(input op_t op);
    return (op >= OP_ADD) && (op <= OP_NOT);
  endfunction

  function automatic logic uses_rs2(input op_t op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

  function automatic logic is_illegal(input op_t op);
    return op[3] && (op != OP_HALT);
  endfunction

endpackage

// File: rtl/scoreboard.sv
// scoreboard: per-register in-flight bits. Set port wins over clear
// port on the same register; three combinational lookups.
// Ports: set_en_i/set_idx_i, clr_en_i/clr_idx_i, rs1/rs2/rd lookups.
module scoreboard
  import pipe_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en_i,
  input  logic [REG_W-1:0] set_idx_i,
  input  logic             clr_en_i,
  input  logic [REG_W-1:0] clr_idx_i,
  input  logic [REG_W-1:0] rs1_idx_i,
  input  logic [REG_W-1:0] rs2_idx_i,
  input  logic [REG_W-1:0] rd_idx_i,
  output logic             rs1_pend_o,
  output logic             rs2_pend_o,
  output logic             rd_pend_o
);

  logic [NREG-1:0] pend_q, pend_d;
  logic [NREG-1:0] set_m, clr_m;

  always_comb begin
    set_m = '0;
    clr_m = '0;
    if (set_en_i) set_m[set_idx_i] = 1'b1;
    if (clr_en_i) clr_m[clr_idx_i] = 1'b1;
    pend_d = (pend_q & ~clr_m) | set_m;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign rs1_pend_o = pend_q[rs1_idx_i];
  assign rs2_pend_o = pend_q[rs2_idx_i];
  assign rd_pend_o  = pend_q[rd_idx_i];

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: decode/operand-fetch stage. One decode slot,
// RAW/WAW stall via scoreboard, registered payload to execute.
// Ports: if_* fetch handshake, src* regfile read, dest_* in-use mark,
// wb_* writeback clear, ex_* execute handshake, illegal, halted.
// rst is active-low and asynchronous.
module operand_fetch
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [DATA_W-1:0] if_instr,
  output logic              if_ready,
  output logic [REG_W-1:0]  src1_idx,
  output logic [REG_W-1:0]  src2_idx,
  input  logic [DATA_W-1:0] src1_val,
  input  logic [DATA_W-1:0] src2_val,
  output logic [REG_W-1:0]  dest_idx,
  output logic              dest_set,
  input  logic              wb_valid,
  input  logic [REG_W-1:0]  wb_dest,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [OP_W-1:0]   ex_op,
  output logic [REG_W-1:0]  ex_dest,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic              illegal,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] slot_q, slot_d;
  ex_t               ex_q, ex_d;
  logic              exv_q, exv_d;
  logic              dset_q, dset_d;
  logic [REG_W-1:0]  didx_q, didx_d;
  logic              ill_q, ill_d;

  op_t              opc;
  logic [REG_W-1:0] rd;
  logic [7:0]       imm;

  assign opc      = slot_q[OP_HI:OP_LO];
  assign rd       = slot_q[RD_HI:RD_LO];
  assign imm      = slot_q[IMM_HI:IMM_LO];
  assign src1_idx = slot_q[RS1_HI:RS1_LO];
  assign src2_idx = slot_q[RS2_HI:RS2_LO];

  logic rs1_pend, rs2_pend, rd_pend;
  logic held, hazard, issue, discard, accept;

  scoreboard u_sb (
    .clk       (clk),
    .rst_n     (rst),
    .set_en_i  (issue),
    .set_idx_i (rd),
    .clr_en_i  (wb_valid),
    .clr_idx_i (wb_dest),
    .rs1_idx_i (src1_idx),
    .rs2_idx_i (src2_idx),
    .rd_idx_i  (rd),
    .rs1_pend_o(rs1_pend),
    .rs2_pend_o(rs2_pend),
    .rd_pend_o (rd_pend)
  );

  assign held    = (state_q == ST_HOLD);
  assign hazard  = (uses_rs1(opc) && rs1_pend)
                || (uses_rs2(opc) && rs2_pend)
                || (is_alu(opc) && rd_pend);
  assign issue   = held && is_alu(opc) && !hazard
                && (!exv_q || ex_ready);
  assign discard = held && !is_alu(opc);

  // A HALT leaving the slot must not pull in a successor:
  // the stage freezes behind it and the fetch would be lost.
  assign if_ready = (state_q == ST_EMPTY)
                 || ((issue || discard) && (opc != OP_HALT));
  assign accept   = if_valid && if_ready;

  logic [DATA_W-1:0] opa, opb;

  always_comb begin
    opa = src1_val;
    opb = src2_val;
    unique case (1'b1)
      opc == OP_LI: begin
        opa = '0;
        opb = {8'h00, imm};
      end
      opc == OP_NOT: opb = '0;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    ex_d    = ex_q;
    exv_d   = exv_q;
    didx_d  = didx_q;
    dset_d  = issue;
    ill_d   = discard && is_illegal(opc);
    if (accept) slot_d = if_instr;
    unique case (state_q)
      ST_EMPTY: if (accept) state_d = ST_HOLD;
      ST_HOLD: begin
        if (discard && opc == OP_HALT)
          state_d = ST_HALTED;
        else if ((issue || discard) && !accept)
          state_d = ST_EMPTY;
      end
      ST_HALTED: state_d = ST_HALTED;
      default: state_d = ST_EMPTY;
    endcase
    if (issue) begin
      exv_d  = 1'b1;
      ex_d   = '{op: opc, dest: rd, a: opa, b: opb};
      didx_d = rd;
    end else if (ex_ready) begin
      exv_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      slot_q  <= '0;
      ex_q    <= '0;
      exv_q   <= 1'b0;
      dset_q  <= 1'b0;
      didx_q  <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      ex_q    <= ex_d;
      exv_q   <= exv_d;
      dset_q  <= dset_d;
      didx_q  <= didx_d;
      ill_q   <= ill_d;
    end
  end

  assign ex_valid = exv_q;
  assign ex_op    = ex_q.op;
  assign ex_dest  = ex_q.dest;
  assign ex_a     = ex_q.a;
  assign ex_b     = ex_q.b;
  assign dest_set = dset_q;
  assign dest_idx = didx_q;
  assign illegal  = ill_q;
  assign halted   = (state_q == ST_HALTED);

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed scenarios plus a randomized run checked
// against an in-order transaction model with a register file array.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [15:0] if_instr;
  logic        if_ready;
  logic [3:0]  src1_idx, src2_idx;
  logic [15:0] src1_val, src2_val;
  logic [3:0]  dest_idx;
  logic        dest_set;
  logic        wb_valid;
  logic [3:0]  wb_dest;
  logic        ex_valid, ex_ready;
  logic [3:0]  ex_op, ex_dest;
  logic [15:0] ex_a, ex_b;
  logic        illegal, halted;

  logic [15:0] regs [16];
  int n_vec = 0;
  int n_err = 0;

  assign src1_val = regs[src1_idx];
  assign src2_val = regs[src2_idx];

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_instr(if_instr), .if_ready(if_ready),
    .src1_idx(src1_idx), .src2_idx(src2_idx),
    .src1_val(src1_val), .src2_val(src2_val),
    .dest_idx(dest_idx), .dest_set(dest_set),
    .wb_valid(wb_valid), .wb_dest(wb_dest),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_op(ex_op), .ex_dest(ex_dest), .ex_a(ex_a), .ex_b(ex_b),
    .illegal(illegal), .halted(halted)
  );

  // Expected execute payload {op, dest, a, b} from the opcode rules.
  function automatic logic [39:0] ref_payload(input logic [15:0] ins);
    logic [3:0]  op;
    logic [15:0] a, b;
    op = ins[15:12];
    a  = regs[ins[7:4]];
    b  = regs[ins[3:0]];
    if (op == 4'h6) b = 16'h0000;
    if (op == 4'h7) begin
      a = 16'h0000;
      b = {8'h00, ins[7:0]};
    end
    return {op, ins[11:8], a, b};
  endfunction

  function automatic bit in_q(input logic [3:0] q[$],
                              input logic [3:0] r);
    foreach (q[k]) if (q[k] == r) return 1'b1;
    return 1'b0;
  endfunction

  // Random instruction; destinations and sources confined to R0-R7.
  function automatic logic [15:0] gen_instr();
    int r;
    logic [3:0]  op;
    logic [15:0] ins;
    r = $urandom_range(0, 15);
    if (r < 12)      op = 4'(1 + r % 7);
    else if (r < 14) op = 4'h0;
    else             op = 4'(8 + $urandom_range(0, 6));
    ins = {op, 1'b0, 3'($urandom), 1'b0, 3'($urandom),
           1'b0, 3'($urandom)};
    if (op == 4'h7) ins[7:0] = 8'($urandom);
    return ins;
  endfunction

  task automatic do_reset();
    if_valid = 1'b0;
    if_instr = 16'h0000;
    wb_valid = 1'b0;
    wb_dest  = 4'h0;
    ex_ready = 1'b1;
    rst      = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    if_valid = 1'b0;
    wb_valid = 1'b0;
    ex_ready = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({if_ready, ex_valid, dest_set, illegal, halted} !== 5'b10000) begin
      n_err++;
      $display("FAIL rst_ctl: got %b want 10000",
               {if_ready, ex_valid, dest_set, illegal, halted});
    end
    n_vec++;
    if (dut.u_sb.pend_q !== 16'h0000) begin
      n_err++;
      $display("FAIL rst_pend: got %h want 0000", dut.u_sb.pend_q);
    end
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({src1_idx, src2_idx, dest_idx, ex_op, ex_dest} !== 20'h0) begin
      n_err++;
      $display("FAIL rst_idx: got %h want 00000",
               {src1_idx, src2_idx, dest_idx, ex_op, ex_dest});
    end
    n_vec++;
    if ({ex_a, ex_b} !== 32'h0) begin
      n_err++;
      $display("FAIL rst_data: got %h want 0", {ex_a, ex_b});
    end
  endtask

  task automatic test_issue();
    do_reset();
    regs[1] = 16'd5;
    regs[2] = 16'd7;
    if_valid = 1'b1;
    if_instr = 16'h1312;
    @(negedge clk);
    if_valid = 1'b0;
    n_vec++;
    if ({ex_valid, src1_idx, src2_idx} !== 9'h012) begin
      n_err++;
      $display("FAIL issue_n1: got %h want 012",
               {ex_valid, src1_idx, src2_idx});
    end
    @(negedge clk);
    n_vec++;
    if ({ex_valid, ex_op, ex_dest, ex_a, ex_b}
        !== {1'b1, 4'h1, 4'h3, 16'd5, 16'd7}) begin
      n_err++;
      $display("FAIL issue_pl: got %h want 11300050007",
               {ex_valid, ex_op, ex_dest, ex_a, ex_b});
    end
    n_vec++;
    if ({dest_set, dest_idx} !== 5'b1_0011) begin
      n_err++;
      $display("FAIL issue_dset: got %b want 10011",
               {dest_set, dest_idx});
    end
    @(negedge clk);
    n_vec++;
    if ({ex_valid, dest_set} !== 2'b00) begin
      n_err++;
      $display("FAIL issue_drop: got %b want 00", {ex_valid, dest_set});
    end
  endtask

  task automatic test_raw();
    do_reset();
    regs[1] = 16'd5;
    regs[2] = 16'd7;
    regs[3] = 16'h0030;
    if_valid = 1'b1;
    if_instr = 16'h1312;
    @(negedge clk);
    if_instr = 16'h2431;
    n_vec++;
    if (if_ready !== 1'b1) begin
      n_err++;
      $display("FAIL raw_rdy1: got %b want 1", if_ready);
    end
    @(negedge clk);
    if_valid = 1'b0;
    n_vec++;
    if ({if_ready, dest_set, dest_idx} !== 6'b01_0011) begin
      n_err++;
      $display("FAIL raw_stall: got %b want 010011",
               {if_ready, dest_set, dest_idx});
    end
    @(negedge clk);
    n_vec++;
    if ({if_ready, dest_set, ex_valid} !== 3'b000) begin
      n_err++;
      $display("FAIL raw_hold: got %b want 000",
               {if_ready, dest_set, ex_valid});
    end
    wb_valid = 1'b1;
    wb_dest  = 4'h3;
    @(negedge clk);
    wb_valid = 1'b0;
    n_vec++;
    if ({if_ready, dest_set} !== 2'b10) begin
      n_err++;
      $display("FAIL raw_w: got %b want 10", {if_ready, dest_set});
    end
    @(negedge clk);
    n_vec++;
    if ({dest_set, dest_idx, ex_op, ex_a, ex_b}
        !== {1'b1, 4'h4, 4'h2, 16'h0030, 16'd5}) begin
      n_err++;
      $display("FAIL raw_w1: got %h want 14200300005",
               {dest_set, dest_idx, ex_op, ex_a, ex_b});
    end
  endtask

  task automatic test_backpressure();
    logic [39:0] first;
    do_reset();
    regs[1] = 16'd5;
    regs[2] = 16'd7;
    ex_ready = 1'b0;
    first = {4'h1, 4'h3, 16'd5, 16'd7};
    if_valid = 1'b1;
    if_instr = 16'h1312;
    @(negedge clk);
    if_instr = 16'h3612;
    @(negedge clk);
    if_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_vec++;
      if ({ex_valid, if_ready, ex_op, ex_dest, ex_a, ex_b}
          !== {2'b10, first}) begin
        n_err++;
        $display("FAIL bp_stable%0d: got %h want %h", c,
                 {ex_valid, if_ready, ex_op, ex_dest, ex_a, ex_b},
                 {2'b10, first});
      end
      if (c == 2) ex_ready = 1'b1;
      @(negedge clk);
    end
    n_vec++;
    if ({ex_valid, ex_op, ex_dest, ex_a, ex_b}
        !== {1'b1, 4'h3, 4'h6, 16'd5, 16'd7}) begin
      n_err++;
      $display("FAIL bp_second: got %h want 13600050007",
               {ex_valid, ex_op, ex_dest, ex_a, ex_b});
    end
    @(negedge clk);
    n_vec++;
    if (ex_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_drain: got %b want 0", ex_valid);
    end
  endtask

  task automatic test_li_nop_illegal();
    do_reset();
    regs[10] = 16'hBEEF;
    regs[5]  = 16'h1234;
    if_valid = 1'b1;
    if_instr = 16'h75A5;
    @(negedge clk);
    if_instr = 16'h0000;
    @(negedge clk);
    if_instr = 16'h9123;
    n_vec++;
    if ({ex_valid, ex_op, ex_dest, ex_a, ex_b}
        !== {1'b1, 4'h7, 4'h5, 16'h0000, 16'h00A5}) begin
      n_err++;
      $display("FAIL li_pl: got %h want 175000000a5",
               {ex_valid, ex_op, ex_dest, ex_a, ex_b});
    end
    @(negedge clk);
    if_valid = 1'b0;
    n_vec++;
    if ({ex_valid, dest_set, illegal} !== 3'b000) begin
      n_err++;
      $display("FAIL nop_quiet: got %b want 000",
               {ex_valid, dest_set, illegal});
    end
    @(negedge clk);
    n_vec++;
    if ({ex_valid, dest_set, illegal} !== 3'b001) begin
      n_err++;
      $display("FAIL ill_pulse: got %b want 001",
               {ex_valid, dest_set, illegal});
    end
    @(negedge clk);
    n_vec++;
    if ({ex_valid, illegal, if_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL ill_once: got %b want 001",
               {ex_valid, illegal, if_ready});
    end
  endtask

  task automatic test_waw();
    do_reset();
    if_valid = 1'b1;
    if_instr = 16'h7311;
    @(negedge clk);
    if_instr = 16'h7322;
    @(negedge clk);
    if_valid = 1'b0;
    n_vec++;
    if ({dest_set, if_ready, ex_b} !== {2'b10, 16'h0011}) begin
      n_err++;
      $display("FAIL waw_first: got %h want 20011",
               {dest_set, if_ready, ex_b});
    end
    @(negedge clk);
    n_vec++;
    if ({dest_set, if_ready} !== 2'b00) begin
      n_err++;
      $display("FAIL waw_stall: got %b want 00", {dest_set, if_ready});
    end
    wb_valid = 1'b1;
    wb_dest  = 4'h3;
    @(negedge clk);
    n_vec++;
    if ({dest_set, if_ready, dut.u_sb.pend_q[3]} !== 3'b010) begin
      n_err++;
      $display("FAIL waw_clr: got %b want 010",
               {dest_set, if_ready, dut.u_sb.pend_q[3]});
    end
    @(negedge clk);
    wb_valid = 1'b0;
    n_vec++;
    if ({dest_set, dest_idx, ex_b} !== {1'b1, 4'h3, 16'h0022}) begin
      n_err++;
      $display("FAIL waw_issue: got %h want 130022",
               {dest_set, dest_idx, ex_b});
    end
    n_vec++;
    if (dut.u_sb.pend_q[3] !== 1'b1) begin
      n_err++;
      $display("FAIL same_edge_set: got %b want 1",
               dut.u_sb.pend_q[3]);
    end
  endtask

  task automatic test_halt();
    do_reset();
    if_valid = 1'b1;
    if_instr = 16'hF000;
    @(negedge clk);
    if_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({halted, if_ready, ex_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL halt_enter: got %b want 100",
               {halted, if_ready, ex_valid});
    end
    if_valid = 1'b1;
    if_instr = 16'h1312;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_vec++;
      if ({halted, if_ready, ex_valid, dest_set} !== 4'b1000) begin
        n_err++;
        $display("FAIL halt_frozen%0d: got %b want 1000", c,
                 {halted, if_ready, ex_valid, dest_set});
      end
    end
    if_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    regs[1] = 16'd5;
    regs[2] = 16'd7;
    ex_ready = 1'b0;
    if_valid = 1'b1;
    if_instr = 16'h1312;
    @(negedge clk);
    if_instr = 16'h3612;
    @(negedge clk);
    if_valid = 1'b0;
    n_vec++;
    if ({ex_valid, dest_set, if_ready, dut.u_sb.pend_q[3]}
        !== 4'b1101) begin
      n_err++;
      $display("FAIL rm_pre: got %b want 1101",
               {ex_valid, dest_set, if_ready, dut.u_sb.pend_q[3]});
    end
    #3 rst = 1'b0;
    #1;
    n_vec++;
    if ({if_ready, ex_valid, dest_set, illegal, halted} !== 5'b10000) begin
      n_err++;
      $display("FAIL rm_ctl: got %b want 10000",
               {if_ready, ex_valid, dest_set, illegal, halted});
    end
    n_vec++;
    if (dut.u_sb.pend_q !== 16'h0000) begin
      n_err++;
      $display("FAIL rm_pend: got %h want 0000", dut.u_sb.pend_q);
    end
    n_vec++;
    if ({src1_idx, src2_idx, ex_op, ex_dest, ex_a, ex_b} !== 48'h0) begin
      n_err++;
      $display("FAIL rm_data: got %h want 0",
               {src1_idx, src2_idx, ex_op, ex_dest, ex_a, ex_b});
    end
    @(negedge clk);
    rst = 1'b1;
    ex_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({ex_valid, dest_set, if_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL rm_noreplay: got %b want 001",
               {ex_valid, dest_set, if_ready});
    end
  endtask

  task automatic test_random();
    logic [15:0] iss_q[$];
    logic [39:0] exp_q[$];
    logic [3:0]  outst[$];
    logic [39:0] held_pl, pl, want;
    logic [15:0] ins;
    logic [3:0]  op, wbd;
    bit held, feed, wb_pend, done, got;
    int n_ill_exp, n_ill_got, quiet, idx;
    do_reset();
    for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
    held = 0; wb_pend = 0; done = 0; wbd = 4'h0;
    n_ill_exp = 0; n_ill_got = 0; quiet = 0;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      feed = (cyc < 1500);
      got = 0;
      if (dest_set) begin
        n_vec++;
        if (iss_q.size() == 0) begin
          n_err++;
          $display("FAIL rnd_issue: dest_set=1 want 0 (queue empty)");
        end else begin
          ins = iss_q.pop_front();
          op  = ins[15:12];
          got = 1;
          if (dest_idx !== ins[11:8]) begin
            n_err++;
            $display("FAIL rnd_dest: got %h want %h",
                     dest_idx, ins[11:8]);
          end
          n_vec++;
          if (in_q(outst, ins[11:8])
              || (op <= 4'h6 && in_q(outst, ins[7:4]))
              || (op <= 4'h5 && in_q(outst, ins[3:0]))) begin
            n_err++;
            $display("FAIL rnd_hazard: issued %h want stall", ins);
          end
        end
      end
      if (wb_pend) begin
        idx = -1;
        foreach (outst[k]) if (idx < 0 && outst[k] == wbd) idx = k;
        if (idx >= 0) outst.delete(idx);
      end
      if (got) outst.push_back(ins[11:8]);
      if (illegal) n_ill_got++;
      if (held) begin
        n_vec++;
        if ({ex_valid, ex_op, ex_dest, ex_a, ex_b} !== {1'b1, held_pl}) begin
          n_err++;
          $display("FAIL rnd_stable: got %h want %h",
                   {ex_valid, ex_op, ex_dest, ex_a, ex_b},
                   {1'b1, held_pl});
        end
      end
      ex_ready = ($urandom_range(0, 3) != 0);
      pl = {ex_op, ex_dest, ex_a, ex_b};
      held = 0;
      if (ex_valid && ex_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rnd_extra: got %h want none", pl);
        end else begin
          want = exp_q.pop_front();
          if (pl !== want) begin
            n_err++;
            $display("FAIL rnd_payload: got %h want %h", pl, want);
          end
        end
      end else if (ex_valid) begin
        held = 1;
        held_pl = pl;
      end
      wb_pend = 0;
      if (outst.size() > 0 && (!feed || $urandom_range(0, 2) == 0)) begin
        wbd = outst[$urandom_range(0, outst.size() - 1)];
        wb_pend = 1;
      end else if ($urandom_range(0, 15) == 0) begin
        wbd = 4'($urandom_range(8, 15));
        wb_pend = 1;
      end
      wb_valid = wb_pend;
      wb_dest  = wbd;
      if_valid = feed && ($urandom_range(0, 3) != 0);
      if_instr = gen_instr();
      #1;
      if (if_valid && if_ready) begin
        op = if_instr[15:12];
        if (op >= 4'h1 && op <= 4'h7) begin
          iss_q.push_back(if_instr);
          exp_q.push_back(ref_payload(if_instr));
        end else if (op >= 4'h8 && op <= 4'hE) begin
          n_ill_exp++;
        end
      end
      if (!feed && iss_q.size() == 0 && exp_q.size() == 0
          && !ex_valid && !illegal && if_ready) quiet++;
      else quiet = 0;
      if (quiet >= 3) done = 1;
      @(negedge clk);
    end
    wb_valid = 1'b0;
    if_valid = 1'b0;
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL rnd_drain: %0d issues %0d payloads left want 0",
               iss_q.size(), exp_q.size());
    end
    n_vec++;
    if (n_ill_got != n_ill_exp) begin
      n_err++;
      $display("FAIL rnd_illegal: got %0d want %0d",
               n_ill_got, n_ill_exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    if_valid = 1'b0;
    if_instr = 16'h0000;
    wb_valid = 1'b0;
    wb_dest = 4'h0;
    ex_ready = 1'b1;
    for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
    test_reset();
    test_issue();
    test_raw();
    test_backpressure();
    test_li_nop_illegal();
    test_waw();
    test_halt();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
